// File: rtl/bridge_txn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_txn_sequencer
//  Purpose  : Takes one parsed host frame at a time and runs it on the
//             register bus. It checks size and alignment, then splits the
//             command into bus beats. For writes it assembles byte lanes from
//             the parser buffer. For reads it unpacks bus data into the
//             response buffer. It then launches the response builder and
//             finally releases the parser.
//  Ports    : clk/rst_n             - clock, synchronous active-low reset
//             frame_* / cmd / addr  - parser handshake and frame header
//             data_rd_* / data_count- parser data buffer read port
//             bus_*                 - register-bus master beat interface
//             rbuf_*                - response data buffer write port
//             resp_*                - response builder job and handshake
//             busy                  - high whenever not idle
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_txn_sequencer #(
    parameter int BUS_TIMEOUT_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic        frame_error,
    input  logic [7:0]  error_status,
    input  logic [7:0]  cmd,
    input  logic [31:0] addr,
    output logic [5:0]  data_rd_idx,
    input  logic [7:0]  data_rd_byte,
    input  logic [5:0]  data_count,
    output logic        frame_consumed,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        rbuf_we,
    output logic [5:0]  rbuf_idx,
    output logic [7:0]  rbuf_byte,
    output logic        resp_start,
    output logic [7:0]  resp_status,
    output logic [7:0]  resp_cmd,
    output logic [31:0] resp_addr,
    output logic [6:0]  resp_len,
    input  logic        resp_done,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CHECK     = 4'd1;
    localparam logic [3:0] S_ASSEMBLE  = 4'd2;
    localparam logic [3:0] S_BUS       = 4'd3;
    localparam logic [3:0] S_UNPACK    = 4'd4;
    localparam logic [3:0] S_NEXT      = 4'd5;
    localparam logic [3:0] S_RESP      = 4'd6;
    localparam logic [3:0] S_WAIT_RESP = 4'd7;
    localparam logic [3:0] S_CONSUME   = 4'd8;
    localparam logic [3:0] S_DRAIN     = 4'd9;

    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_SIZE    = 8'h02;
    localparam logic [7:0] STS_ALIGN   = 8'h03;
    localparam logic [7:0] STS_TIMEOUT = 8'h04;
    localparam logic [7:0] STS_BUSERR  = 8'h05;
    localparam logic [7:0] STS_LENGTH  = 8'h07;

    // The counter only has to reach BUS_TIMEOUT_CYCLES-1; the expiring cycle
    // is detected by comparing against that last value.
    localparam int              TMO_W    = (BUS_TIMEOUT_CYCLES > 1) ? $clog2(BUS_TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0]       state_q,  state_d;
    logic [7:0]       cmd_q,    cmd_d;
    logic [31:0]      addr_q,   addr_d;
    logic [3:0]       beat_q,   beat_d;
    logic [1:0]       byte_q,   byte_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic [7:0]       status_q, status_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic [31:0]      rdata_q,  rdata_d;
    logic [6:0]       len_q,    len_d;

    // ------------------------------------------------------------------------
    // Beat geometry from the latched command
    // ------------------------------------------------------------------------
    logic        w_rw;
    logic        w_inc;
    logic [1:0]  w_size;
    logic [4:0]  w_beats;
    logic [6:0]  w_total;
    logic [1:0]  w_bpb_m1;
    logic        w_last_byte;
    logic        w_last_beat;
    logic [31:0] w_off;
    logic [31:0] w_ba;
    logic [1:0]  w_lane;
    logic [5:0]  w_idx;
    logic [3:0]  w_strb;

    assign w_rw        = cmd_q[7];
    assign w_inc       = cmd_q[6];
    assign w_size      = cmd_q[5:4];
    assign w_beats     = {1'b0, cmd_q[3:0]} + 5'd1;
    assign w_total     = {2'b00, w_beats} << w_size;
    assign w_bpb_m1    = (w_size == 2'd0) ? 2'd0 : ((w_size == 2'd1) ? 2'd1 : 2'd3);
    assign w_last_byte = (byte_q == w_bpb_m1);
    assign w_last_beat = (beat_q == cmd_q[3:0]);
    // Address arithmetic is plain 32-bit addition, so bursts wrap past 0xFFFFFFFF.
    assign w_off       = w_inc ? ({28'd0, beat_q} << w_size) : 32'd0;
    assign w_ba        = addr_q + w_off;
    // Little-endian: byte j of the beat sits at lane (start lane + j).
    assign w_lane      = w_ba[1:0] + byte_q;
    assign w_idx       = ({2'b00, beat_q} << w_size) + {4'd0, byte_q};

    always_comb begin
        w_strb = 4'hF;
        case (w_size)
            2'd0:    w_strb = 4'b0001 << w_ba[1:0];
            2'd1:    w_strb = w_ba[1] ? 4'b1100 : 4'b0011;
            default: w_strb = 4'hF;
        endcase
    end

    // ------------------------------------------------------------------------
    // Header checks on the live parser inputs (used only in CHECK)
    // ------------------------------------------------------------------------
    logic [1:0] w_chk_size;
    logic [4:0] w_chk_beats;
    logic [6:0] w_chk_total;

    assign w_chk_size  = cmd[5:4];
    assign w_chk_beats = {1'b0, cmd[3:0]} + 5'd1;
    assign w_chk_total = {2'b00, w_chk_beats} << w_chk_size;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        byte_d   = byte_q;
        tmo_d    = tmo_q;
        status_d = status_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        len_d    = len_q;

        data_rd_idx    = 6'd0;
        frame_consumed = 1'b0;
        bus_req        = 1'b0;
        bus_we         = 1'b0;
        bus_addr       = 32'd0;
        bus_wdata      = 32'd0;
        bus_wstrb      = 4'd0;
        rbuf_we        = 1'b0;
        rbuf_idx       = 6'd0;
        rbuf_byte      = 8'd0;
        resp_start     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_error) begin
                    // Parser-reported failures skip the bus entirely; the
                    // header is still captured so the response echoes it.
                    cmd_d    = cmd;
                    addr_d   = addr;
                    len_d    = 7'd0;
                    status_d = error_status;
                    state_d  = S_RESP;
                end else if (frame_valid) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                cmd_d    = cmd;
                addr_d   = addr;
                beat_d   = 4'd0;
                byte_d   = 2'd0;
                tmo_d    = '0;
                wdata_d  = 32'd0;
                rdata_d  = 32'd0;
                len_d    = 7'd0;
                status_d = STS_OK;
                if (w_chk_size == 2'd3) begin
                    status_d = STS_SIZE;
                    state_d  = S_RESP;
                end else if (((w_chk_size == 2'd1) && addr[0]) ||
                             ((w_chk_size == 2'd2) && (addr[1:0] != 2'd0))) begin
                    status_d = STS_ALIGN;
                    state_d  = S_RESP;
                end else if (!cmd[7] && ({1'b0, data_count} != w_chk_total)) begin
                    status_d = STS_LENGTH;
                    state_d  = S_RESP;
                end else begin
                    state_d = cmd[7] ? S_BUS : S_ASSEMBLE;
                end
            end

            S_ASSEMBLE: begin
                data_rd_idx = w_idx;
                // The first byte of each beat starts from a clean word so
                // lanes not covered by this beat read as zero.
                if (byte_q == 2'd0) begin
                    wdata_d = 32'd0;
                end
                wdata_d[{w_lane, 3'b000} +: 8] = data_rd_byte;
                if (w_last_byte) begin
                    byte_d  = 2'd0;
                    tmo_d   = '0;
                    state_d = S_BUS;
                end else begin
                    byte_d = byte_q + 2'd1;
                end
            end

            S_BUS: begin
                bus_req   = 1'b1;
                bus_we    = ~w_rw;
                bus_addr  = {w_ba[31:2], 2'b00};
                bus_wdata = wdata_q;
                bus_wstrb = w_strb;
                // An ack in the expiring cycle wins over the timeout.
                if (bus_ack) begin
                    tmo_d = '0;
                    if (bus_err) begin
                        status_d = STS_BUSERR;
                        state_d  = S_RESP;
                    end else if (w_rw) begin
                        rdata_d = bus_rdata;
                        byte_d  = 2'd0;
                        state_d = S_UNPACK;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d    = '0;
                    status_d = STS_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            S_UNPACK: begin
                rbuf_we   = 1'b1;
                rbuf_idx  = w_idx;
                rbuf_byte = rdata_q[{w_lane, 3'b000} +: 8];
                if (w_last_byte) begin
                    byte_d  = 2'd0;
                    state_d = S_NEXT;
                end else begin
                    byte_d = byte_q + 2'd1;
                end
            end

            S_NEXT: begin
                byte_d = 2'd0;
                tmo_d  = '0;
                if (w_last_beat) begin
                    status_d = STS_OK;
                    len_d    = w_rw ? w_total : 7'd0;
                    state_d  = S_RESP;
                end else begin
                    beat_d  = beat_q + 4'd1;
                    state_d = w_rw ? S_BUS : S_ASSEMBLE;
                end
            end

            S_RESP: begin
                resp_start = 1'b1;
                state_d    = S_WAIT_RESP;
            end

            S_WAIT_RESP: begin
                if (resp_done) begin
                    state_d = S_CONSUME;
                end
            end

            S_CONSUME: begin
                frame_consumed = 1'b1;
                state_d        = S_DRAIN;
            end

            S_DRAIN: begin
                // Wait for the parser to withdraw the frame so the same
                // frame is never picked up twice.
                if (!frame_valid && !frame_error) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cmd_q    <= 8'd0;
            addr_q   <= 32'd0;
            beat_q   <= 4'd0;
            byte_q   <= 2'd0;
            tmo_q    <= '0;
            status_q <= 8'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            len_q    <= 7'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            byte_q   <= byte_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            len_q    <= len_d;
        end
    end

    assign resp_status = status_q;
    assign resp_cmd    = cmd_q;
    assign resp_addr   = addr_q;
    assign resp_len    = len_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bridge_txn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bridge_txn_sequencer
//  Purpose  : Directed self-checking bench for bridge_txn_sequencer. A bus
//             responder and a response-builder model run on the falling
//             edge. Directed frames are checked against hand-computed
//             beats, buffer bytes and status codes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_txn_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_error = 1'b0;
    logic [7:0]  error_status = 8'd0;
    logic [7:0]  cmd = 8'd0;
    logic [31:0] addr = 32'd0;
    logic [5:0]  data_rd_idx;
    logic [7:0]  data_rd_byte;
    logic [5:0]  data_count = 6'd0;
    logic        frame_consumed;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        rbuf_we;
    logic [5:0]  rbuf_idx;
    logic [7:0]  rbuf_byte;
    logic        resp_start;
    logic [7:0]  resp_status;
    logic [7:0]  resp_cmd;
    logic [31:0] resp_addr;
    logic [6:0]  resp_len;
    logic        resp_done = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    bridge_txn_sequencer #(.BUS_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(frame_valid), .frame_error(frame_error), .error_status(error_status),
        .cmd(cmd), .addr(addr),
        .data_rd_idx(data_rd_idx), .data_rd_byte(data_rd_byte), .data_count(data_count),
        .frame_consumed(frame_consumed),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .rbuf_we(rbuf_we), .rbuf_idx(rbuf_idx), .rbuf_byte(rbuf_byte),
        .resp_start(resp_start), .resp_status(resp_status), .resp_cmd(resp_cmd),
        .resp_addr(resp_addr), .resp_len(resp_len), .resp_done(resp_done),
        .busy(busy)
    );

    // Parser data buffer (combinational read)
    logic [7:0] pbuf [64];
    assign data_rd_byte = pbuf[data_rd_idx];

    // Knobs owned by the main sequence
    logic        ack_never = 1'b0;
    int          err_at    = 1000;
    logic [31:0] rd_val    = 32'd0;

    // Observations owned by the falling-edge monitor
    int          beat_total = 0;
    int          req_total  = 0;
    int          cons_total = 0;
    int          rbw_total  = 0;
    int          busy_cyc   = 0;
    int          rs_lat     = 0;
    int          done_cnt   = 0;
    logic        busy_prev  = 1'b0;
    logic [7:0]  rs_status  = 8'd0;
    logic [6:0]  rs_len     = 7'd0;
    logic [31:0] b_addr  [64];
    logic [31:0] b_wdata [64];
    logic [3:0]  b_wstrb [64];
    logic        b_we    [64];
    logic [7:0]  rbuf_mem[64];

    // Snapshots taken by the main sequence at frame start
    int beat_base, req_base, cons_base, rbw_base;

    int n_vec  = 0;
    int n_miss = 0;

    always @(negedge clk) begin
        // Bus responder: zero-wait ack unless ack_never is set.
        if (bus_ack) begin
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end else if (bus_req) begin
            req_total++;
            if (!ack_never) begin
                b_addr [beat_total[5:0]] = bus_addr;
                b_wdata[beat_total[5:0]] = bus_wdata;
                b_wstrb[beat_total[5:0]] = bus_wstrb;
                b_we   [beat_total[5:0]] = bus_we;
                bus_err   = (beat_total == err_at);
                bus_rdata = rd_val;
                bus_ack   = 1'b1;
                beat_total++;
            end
        end
        if (rbuf_we) begin
            rbuf_mem[rbuf_idx] = rbuf_byte;
            rbw_total++;
        end
        if (frame_consumed) cons_total++;
        if (busy) busy_cyc = busy_prev ? busy_cyc + 1 : 1;
        busy_prev = busy;
        // Response builder: done two cycles after start.
        if (resp_done) begin
            resp_done = 1'b0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) resp_done = 1'b1;
        end
        if (resp_start) begin
            rs_lat    = busy_cyc;
            rs_status = resp_status;
            rs_len    = resp_len;
            done_cnt  = 2;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit is_err, input logic [7:0] c, input logic [31:0] a,
                             input logic [5:0] dc, input logic [7:0] es);
        int budget;
        beat_base = beat_total;
        req_base  = req_total;
        cons_base = cons_total;
        rbw_base  = rbw_total;
        cmd = c; addr = a; data_count = dc; error_status = es;
        if (is_err) frame_error = 1'b1;
        else        frame_valid = 1'b1;
        budget = 0;
        while (cons_total == cons_base && budget < 400) begin
            tick();
            budget++;
        end
        check_eq("frame_done", 64'(cons_total != cons_base), 64'd1);
        repeat (3) tick();
        check_eq("drain_hold", 64'(busy), 64'd1);
        frame_valid = 1'b0;
        frame_error = 1'b0;
        tick();
        check_eq("drain_exit", 64'(busy), 64'd0);
        check_eq("consume_once", 64'(cons_total - cons_base), 64'd1);
    endtask

    function automatic logic any_out();
        return |{bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, rbuf_we, rbuf_idx,
                 rbuf_byte, resp_start, resp_status, resp_cmd, resp_addr, resp_len,
                 frame_consumed, data_rd_idx, busy};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) pbuf[i] = 8'h00;
        repeat (3) tick();
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_outs", 64'(any_out()), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single aligned 32-bit write: resp_start on the 8th busy cycle.
        pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33; pbuf[3] = 8'h44;
        run_frame(1'b0, 8'h20, 32'h0000_3000, 6'd4, 8'h00);
        check_eq("w1_beats",  64'(beat_total - beat_base), 64'd1);
        check_eq("w1_addr",   64'(b_addr [6'(beat_base)]), 64'h3000);
        check_eq("w1_wdata",  64'(b_wdata[6'(beat_base)]), 64'h44332211);
        check_eq("w1_wstrb",  64'(b_wstrb[6'(beat_base)]), 64'hF);
        check_eq("w1_we",     64'(b_we   [6'(beat_base)]), 64'd1);
        check_eq("w1_status", 64'(rs_status), 64'h00);
        check_eq("w1_lat",    64'(rs_lat), 64'd8);

        // Two-beat 32-bit write with INC set, so the second beat advances by 4.
        for (int i = 0; i < 8; i++) pbuf[i] = 8'(i + 1);
        run_frame(1'b0, 8'h61, 32'h0000_1000, 6'd8, 8'h00);
        check_eq("w2_beats",  64'(beat_total - beat_base), 64'd2);
        check_eq("w2_addr0",  64'(b_addr [6'(beat_base)]), 64'h1000);
        check_eq("w2_data0",  64'(b_wdata[6'(beat_base)]), 64'h04030201);
        check_eq("w2_addr1",  64'(b_addr [6'(beat_base + 1)]), 64'h1004);
        check_eq("w2_data1",  64'(b_wdata[6'(beat_base + 1)]), 64'h08070605);
        check_eq("w2_status", 64'(rs_status), 64'h00);
        check_eq("w2_len",    64'(rs_len), 64'd0);

        // Byte writes with INC wrapping past 0xFFFFFFFF; unused lanes stay zero.
        pbuf[0] = 8'hA5; pbuf[1] = 8'h5A;
        run_frame(1'b0, 8'h41, 32'hFFFF_FFFF, 6'd2, 8'h00);
        check_eq("w3_addr0",  64'(b_addr [6'(beat_base)]), 64'hFFFF_FFFC);
        check_eq("w3_strb0",  64'(b_wstrb[6'(beat_base)]), 64'h8);
        check_eq("w3_data0",  64'(b_wdata[6'(beat_base)]), 64'hA500_0000);
        check_eq("w3_addr1",  64'(b_addr [6'(beat_base + 1)]), 64'h0);
        check_eq("w3_strb1",  64'(b_wstrb[6'(beat_base + 1)]), 64'h1);
        check_eq("w3_data1",  64'(b_wdata[6'(beat_base + 1)]), 64'h0000_005A);

        // Single byte read from lane 3.
        rd_val = 32'hAABB_CCDD;
        run_frame(1'b0, 8'h80, 32'h0000_2003, 6'd0, 8'h00);
        check_eq("r1_addr",   64'(b_addr [6'(beat_base)]), 64'h2000);
        check_eq("r1_strb",   64'(b_wstrb[6'(beat_base)]), 64'h8);
        check_eq("r1_we",     64'(b_we   [6'(beat_base)]), 64'd0);
        check_eq("r1_rbuf0",  64'(rbuf_mem[0]), 64'hAA);
        check_eq("r1_nwr",    64'(rbw_total - rbw_base), 64'd1);
        check_eq("r1_len",    64'(rs_len), 64'd1);
        check_eq("r1_status", 64'(rs_status), 64'h00);

        // Two 16-bit reads with INC: lanes 2/3 then 0/1.
        rd_val = 32'h1122_3344;
        run_frame(1'b0, 8'hD1, 32'h0000_4002, 6'd0, 8'h00);
        check_eq("r2_strb0",  64'(b_wstrb[6'(beat_base)]), 64'hC);
        check_eq("r2_addr1",  64'(b_addr [6'(beat_base + 1)]), 64'h4004);
        check_eq("r2_strb1",  64'(b_wstrb[6'(beat_base + 1)]), 64'h3);
        check_eq("r2_rbuf",   64'({rbuf_mem[0], rbuf_mem[1], rbuf_mem[2], rbuf_mem[3]}), 64'h22114433);
        check_eq("r2_len",    64'(rs_len), 64'd4);

        // Misaligned 16-bit read.
        run_frame(1'b0, 8'h90, 32'h0000_1001, 6'd0, 8'h00);
        check_eq("al_req",    64'(req_total - req_base), 64'd0);
        check_eq("al_status", 64'(rs_status), 64'h03);
        check_eq("al_len",    64'(rs_len), 64'd0);

        // Reserved size code.
        run_frame(1'b0, 8'hB0, 32'h0000_0000, 6'd0, 8'h00);
        check_eq("sz_status", 64'(rs_status), 64'h02);

        // Write byte count mismatch (4 needed, 3 received).
        run_frame(1'b0, 8'h20, 32'h0000_0000, 6'd3, 8'h00);
        check_eq("ln_req",    64'(req_total - req_base), 64'd0);
        check_eq("ln_status", 64'(rs_status), 64'h07);

        // Three-beat write without INC, bus error on the second beat.
        for (int i = 0; i < 12; i++) pbuf[i] = 8'(8'h10 + i);
        err_at = beat_total + 1;
        run_frame(1'b0, 8'h22, 32'h0000_7000, 6'd12, 8'h00);
        err_at = 1000;
        check_eq("be_beats",  64'(beat_total - beat_base), 64'd2);
        check_eq("be_req",    64'(req_total - req_base), 64'd2);
        check_eq("be_data0",  64'(b_wdata[6'(beat_base)]), 64'h13121110);
        check_eq("be_addr1",  64'(b_addr [6'(beat_base + 1)]), 64'h7000);
        check_eq("be_data1",  64'(b_wdata[6'(beat_base + 1)]), 64'h17161514);
        check_eq("be_status", 64'(rs_status), 64'h05);

        // Parser-reported error: straight to the response, no bus traffic.
        run_frame(1'b1, 8'h80, 32'h0000_0000, 6'd0, 8'h01);
        check_eq("fe_req",    64'(req_total - req_base), 64'd0);
        check_eq("fe_status", 64'(rs_status), 64'h01);
        check_eq("fe_len",    64'(rs_len), 64'd0);

        // Never-acked beat times out after TMO request cycles.
        ack_never = 1'b1;
        pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03; pbuf[3] = 8'h04;
        run_frame(1'b0, 8'h20, 32'h0000_5000, 6'd4, 8'h00);
        ack_never = 1'b0;
        check_eq("to_req",    64'(req_total - req_base), 64'(TMO));
        check_eq("to_status", 64'(rs_status), 64'h04);

        // Reset while assembling a second frame.
        cmd = 8'h20; addr = 32'h0000_8000; data_count = 6'd4; frame_valid = 1'b1;
        tick();
        tick();
        tick();
        check_eq("ra_idx",    64'(data_rd_idx), 64'd1);
        rst_n = 1'b0;
        frame_valid = 1'b0;
        tick();
        check_eq("ra_busy",   64'(busy), 64'd0);
        check_eq("ra_outs",   64'(any_out()), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
